// File: rtl/corefifo_wr_ptr_ctrl_vdma.sv
// Write-side pointer controller for the VDMA FIFO: synchronises the read gray
// pointer, tracks the write pointers and produces fill level and status flags.
module corefifo_wr_ptr_ctrl_vdma #(
  parameter int ADDRWIDTH   = 3,
  parameter int AFULL_VAL   = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [ADDRWIDTH:0]   rd_ptr_gray,
  output logic                 mem_we,
  output logic [ADDRWIDTH-1:0] wr_addr,
  output logic [ADDRWIDTH:0]   wr_ptr_gray,
  output logic                 full,
  output logic                 afull,
  output logic [ADDRWIDTH:0]   wr_cnt,
  output logic                 overflow
);

  localparam int PW = ADDRWIDTH + 1;
  localparam logic [PW-1:0] FULL_CNT  = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [PW-1:0] AFULL_CNT = PW'(AFULL_VAL);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rd_gray_s;
  logic [PW-1:0] rd_bin_s;

  logic [PW-1:0] wr_ptr_bin_q, wr_ptr_bin_d;
  logic [PW-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [PW-1:0] wr_cnt_q, wr_cnt_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          overflow_q, overflow_d;
  logic          we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rd_gray_s = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all gray bits at or above it.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
      assign rd_bin_s[gi] = ^rd_gray_s[PW-1:gi];
    end
  endgenerate

  assign we = wr_en & ~full_q;

  always_comb begin
    wr_ptr_bin_d  = wr_ptr_bin_q + {{ADDRWIDTH{1'b0}}, we};
    wr_ptr_gray_d = wr_ptr_bin_d ^ (wr_ptr_bin_d >> 1);
    wr_cnt_d      = wr_ptr_bin_d - rd_bin_s;
    full_d        = (wr_cnt_d == FULL_CNT);
    afull_d       = (wr_cnt_d >= AFULL_CNT);
    overflow_d    = wr_en & full_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      wr_cnt_q      <= '0;
      full_q        <= 1'b0;
      afull_q       <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_bin_q  <= wr_ptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      wr_cnt_q      <= wr_cnt_d;
      full_q        <= full_d;
      afull_q       <= afull_d;
      overflow_q    <= overflow_d;
    end
  end

  assign mem_we      = we;
  assign wr_addr     = wr_ptr_bin_q[ADDRWIDTH-1:0];
  assign wr_ptr_gray = wr_ptr_gray_q;
  assign full        = full_q;
  assign afull       = afull_q;
  assign wr_cnt      = wr_cnt_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_corefifo_wr_ptr_ctrl_vdma.sv
// Bench for the write-side pointer controller: a reference model pushes the
// expected post-edge outputs when stimulus is driven; tasks pop and compare.
module tb_corefifo_wr_ptr_ctrl_vdma;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] rd_ptr_gray = 4'h0;
  logic       mem_we;
  logic [2:0] wr_addr;
  logic [3:0] wr_ptr_gray;
  logic       full;
  logic       afull;
  logic [3:0] wr_cnt;
  logic       overflow;

  corefifo_wr_ptr_ctrl_vdma #(.ADDRWIDTH(3), .AFULL_VAL(6), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_ptr_gray(rd_ptr_gray),
    .mem_we(mem_we), .wr_addr(wr_addr), .wr_ptr_gray(wr_ptr_gray), .full(full),
    .afull(afull), .wr_cnt(wr_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] gray;
    logic [2:0] addr;
    logic       full;
    logic       afull;
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  logic [3:0] m_wr;
  logic       m_full;
  logic [3:0] m_pipe0, m_pipe1;

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wr = 4'h0; m_full = 1'b0; m_pipe0 = 4'h0; m_pipe1 = 4'h0;
    sb.delete();
  endtask

  // Drive inputs for the coming edge and push what the outputs must be after it.
  task automatic drive(input logic w, input logic [3:0] rg);
    exp_t e;
    logic [3:0] nb, c;
    wr_en = w;
    rd_ptr_gray = rg;
    e.we   = w & ~m_full;
    e.ovf  = w & m_full;
    nb     = m_wr + {3'b000, e.we};
    c      = nb - g2b(m_pipe1);
    m_wr   = nb;
    m_full = (c == 4'd8);
    e.full = m_full;
    e.afull = (c >= 4'd6);
    e.cnt  = c;
    e.gray = b2g(nb);
    e.addr = nb[2:0];
    m_pipe1 = m_pipe0;
    m_pipe0 = rg;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b0; rd_ptr_gray = 4'h0;
    repeat (3) step();
    total_cnt++; if (wr_addr !== 3'd0) $display("FAIL reset_addr got %0d want 0", wr_addr); else pass_cnt++;
    total_cnt++; if (wr_ptr_gray !== 4'h0) $display("FAIL reset_gray got %h want 0", wr_ptr_gray); else pass_cnt++;
    total_cnt++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else pass_cnt++;
    total_cnt++; if (afull !== 1'b0) $display("FAIL reset_afull got %b want 0", afull); else pass_cnt++;
    total_cnt++; if (wr_cnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", wr_cnt); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else pass_cnt++;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL reset_we got %b want 0", mem_we); else pass_cnt++;
    reset_n = 1'b1;
    model_reset();
    $display("reset: outputs cleared");
  endtask

  task automatic test_fill();
    logic [3:0] gtab [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'h0);
      #1;
      total_cnt++; if (mem_we !== sb[$].we) $display("FAIL fill_we[%0d] got %b want %b", i, mem_we, sb[$].we); else pass_cnt++;
      total_cnt++; if (wr_addr !== 3'(i)) $display("FAIL fill_addr[%0d] got %0d want %0d", i, wr_addr, i); else pass_cnt++;
      step();
      e = sb.pop_front();
      total_cnt++; if (wr_ptr_gray !== gtab[i] || wr_ptr_gray !== e.gray) $display("FAIL fill_gray[%0d] got %h want %h", i, wr_ptr_gray, gtab[i]); else pass_cnt++;
      total_cnt++; if (wr_cnt !== e.cnt) $display("FAIL fill_cnt[%0d] got %0d want %0d", i, wr_cnt, e.cnt); else pass_cnt++;
      total_cnt++; if (afull !== e.afull || afull !== (i >= 5)) $display("FAIL fill_afull[%0d] got %b want %b", i, afull, e.afull); else pass_cnt++;
      total_cnt++; if (full !== e.full) $display("FAIL fill_full[%0d] got %b want %b", i, full, e.full); else pass_cnt++;
      $display("fill[%0d]: gray=%h addr=%0d cnt=%0d afull=%b full=%b", i, wr_ptr_gray, wr_addr, wr_cnt, afull, full);
    end
    total_cnt++; if (full !== 1'b1 || wr_cnt !== 4'd8) $display("FAIL fill_end got full=%b cnt=%0d want full=1 cnt=8", full, wr_cnt); else pass_cnt++;
  endtask

  task automatic test_overflow();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, 4'h0);
      #1;
      total_cnt++; if (mem_we !== 1'b0) $display("FAIL ovf_we[%0d] got %b want 0", i, mem_we); else pass_cnt++;
      step();
      e = sb.pop_front();
      total_cnt++; if (wr_ptr_gray !== 4'hC) $display("FAIL ovf_gray[%0d] got %h want c", i, wr_ptr_gray); else pass_cnt++;
      total_cnt++; if (overflow !== e.ovf || overflow !== (i < 2)) $display("FAIL ovf_pulse[%0d] got %b want %b", i, overflow, e.ovf); else pass_cnt++;
      $display("overflow[%0d]: gray=%h overflow=%b full=%b", i, wr_ptr_gray, overflow, full);
    end
  endtask

  task automatic test_drain();
    exp_t e;
    logic [3:0] rds [2] = '{4'h1, 4'h3};
    logic [3:0] want_cnt [2] = '{4'd7, 4'd6};
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        drive(1'b0, rds[r]);
        step();
        e = sb.pop_front();
        total_cnt++; if (wr_cnt !== e.cnt) $display("FAIL drain_cnt[%0d.%0d] got %0d want %0d", r, k, wr_cnt, e.cnt); else pass_cnt++;
        total_cnt++; if (full !== e.full) $display("FAIL drain_full[%0d.%0d] got %b want %b", r, k, full, e.full); else pass_cnt++;
        $display("drain[%0d.%0d]: rd=%h cnt=%0d full=%b afull=%b", r, k, rds[r], wr_cnt, full, afull);
      end
      total_cnt++; if (wr_cnt !== want_cnt[r] || afull !== 1'b1) $display("FAIL drain_end[%0d] got cnt=%0d afull=%b want cnt=%0d afull=1", r, wr_cnt, afull, want_cnt[r]); else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [3:0] prev_gray;
    logic [2:0] prev_addr;
    logic       seen_wrap = 1'b0;
    logic       any_full = 1'b0;
    for (int b = 3; b <= 7; b++) begin
      drive(1'b0, b2g(4'(b)));
      step();
      void'(sb.pop_front());
    end
    for (int i = 0; i < 16; i++) begin
      prev_gray = wr_ptr_gray;
      prev_addr = wr_addr;
      drive(1'b1, b2g(m_wr));
      step();
      e = sb.pop_front();
      total_cnt++; if (wr_ptr_gray !== e.gray || wr_addr !== e.addr) $display("FAIL wrap_ptr[%0d] got %h/%0d want %h/%0d", i, wr_ptr_gray, wr_addr, e.gray, e.addr); else pass_cnt++;
      total_cnt++; if (wr_cnt !== e.cnt) $display("FAIL wrap_cnt[%0d] got %0d want %0d", i, wr_cnt, e.cnt); else pass_cnt++;
      if (full) any_full = 1'b1;
      if (prev_gray == 4'h8 && wr_ptr_gray == 4'h0 && prev_addr == 3'd7 && wr_addr == 3'd0) seen_wrap = 1'b1;
      $display("wrap[%0d]: gray=%h addr=%0d cnt=%0d full=%b", i, wr_ptr_gray, wr_addr, wr_cnt, full);
    end
    total_cnt++; if (seen_wrap !== 1'b1) $display("FAIL wrap_seen got %b want 1", seen_wrap); else pass_cnt++;
    total_cnt++; if (any_full !== 1'b0) $display("FAIL wrap_full got %b want 0", any_full); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    exp_t e;
    reset_n = 1'b0;
    #2;
    step();
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'h0);
      step();
      void'(sb.pop_front());
    end
    wr_en = 1'b0;
    total_cnt++; if (wr_cnt !== 4'd5) $display("FAIL areset_pre got %0d want 5", wr_cnt); else pass_cnt++;
    #3;
    reset_n = 1'b0;
    #1;
    total_cnt++; if ({wr_addr, wr_ptr_gray, full, afull, wr_cnt, overflow, mem_we} !== 16'h0)
      $display("FAIL areset_clear got addr=%0d gray=%h full=%b afull=%b cnt=%0d ovf=%b we=%b want all 0",
               wr_addr, wr_ptr_gray, full, afull, wr_cnt, overflow, mem_we);
    else pass_cnt++;
    $display("async_reset: cleared between edges");
    step();
    reset_n = 1'b1;
    model_reset();
    drive(1'b1, 4'h0);
    step();
    e = sb.pop_front();
    total_cnt++; if (wr_ptr_gray !== 4'h1 || wr_ptr_gray !== e.gray) $display("FAIL areset_gray got %h want 1", wr_ptr_gray); else pass_cnt++;
    total_cnt++; if (wr_cnt !== 4'd1 || wr_cnt !== e.cnt) $display("FAIL areset_cnt got %0d want 1", wr_cnt); else pass_cnt++;
    $display("async_reset: first write gray=%h cnt=%0d", wr_ptr_gray, wr_cnt);
    wr_en = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
